// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the load-value clamp used by the BCD up/down counter.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic bcd_t bcd_sat(input bcd_t x);
        return (x > BCD_MAX) ? BCD_MAX : x;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: combinational next value plus carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_t value_i,
    input  logic step_i,
    input  logic up_i,
    input  logic cin_i,
    output bcd_t next_o,
    output logic cout_o
);

    // Next digit value; cin_i means "carry in" when counting up, "borrow in" when counting down
    always_comb begin
        next_o = value_i;
        cout_o = 1'b0;
        if (step_i && cin_i) begin
            if (up_i) begin
                if (value_i >= BCD_MAX) begin
                    next_o = BCD_MIN;
                    cout_o = 1'b1;
                end else begin
                    next_o = value_i + 4'd1;
                    cout_o = 1'b0;
                end
            end else begin
                if (value_i == BCD_MIN) begin
                    next_o = BCD_MAX;
                    cout_o = 1'b1;
                end else begin
                    next_o = value_i - 4'd1;
                    cout_o = 1'b0;
                end
            end
        end else begin
            next_o = value_i;
            cout_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, clear, load, tick and wrap pulses.
// Optional macro BCD_SATURATE_EN: hold at all-9 / all-0 instead of wrapping.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 10000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_load_val,
    output logic [4*N_DIGITS-1:0] o_digits,
    output logic                  o_tick,
    output logic                  o_wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         pre_q, pre_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [4*N_DIGITS-1:0] chain_s, load_s;
    logic                  tick_q, tick_d, wrap_q, wrap_d;
    logic                  step_s, top_carry_s;

    assign step_s = i_en & (pre_q == PRE_LAST);

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic cin_s, cout_s;
        if (k == 0) begin : g_lsd
            assign cin_s = 1'b1;
        end else begin : g_chain
            assign cin_s = g_digit[k-1].cout_s;
        end
        bcd_digit u_digit (
            .value_i (digits_q[4*k +: 4]),
            .step_i  (step_s),
            .up_i    (i_up),
            .cin_i   (cin_s),
            .next_o  (chain_s[4*k +: 4]),
            .cout_o  (cout_s)
        );
        assign load_s[4*k +: 4] = bcd_sat(i_load_val[4*k +: 4]);
    end

    assign top_carry_s = g_digit[N_DIGITS-1].cout_s;

    // Next-state selection: clear beats load beats a counting step
    always_comb begin
        digits_d = digits_q;
        pre_d    = pre_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        if (i_clear) begin
            digits_d = {(4*N_DIGITS){1'b0}};
            pre_d    = {PW{1'b0}};
        end else if (i_load) begin
            digits_d = load_s;
            pre_d    = {PW{1'b0}};
        end else if (i_en) begin
            pre_d = (pre_q == PRE_LAST) ? {PW{1'b0}} : pre_q + PW'(1);
            if (step_s) begin
                tick_d = 1'b1;
                wrap_d = top_carry_s;
`ifdef BCD_SATURATE_EN
                digits_d = top_carry_s ? digits_q : chain_s;
`else
                digits_d = chain_s;
`endif
            end else begin
                digits_d = digits_q;
            end
        end else begin
            digits_d = digits_q;
            pre_d    = pre_q;
        end
    end

    // State and output pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q    <= {PW{1'b0}};
            digits_q <= {(4*N_DIGITS){1'b0}};
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            digits_q <= digits_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign o_digits = digits_q;
    assign o_tick   = tick_q;
    assign o_wrap   = wrap_q;

endmodule
